// File: rtl/alu_exec_unit_if.sv
// Request/response bundle for the EX-stage ALU. It carries the decode fields and operands in,
// the registered result and flags out, a valid/ready pair on each side, and flush.
interface alu_exec_unit_if #(
   parameter int XLEN = 32
);
   logic            flush;
   logic            in_valid;
   logic            in_ready;
   logic [1:0]      ALUop;
   logic [2:0]      function_3bit;
   logic [6:0]      function_7bit;
   logic [6:0]      opcode_instruction;
   logic [XLEN-1:0] src_a;
   logic [XLEN-1:0] src_b;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] result;
   logic            zero;
   logic [3:0]      ALUcontrol;
   logic            illegal;

   modport master (
      output flush, in_valid, ALUop, function_3bit, function_7bit,
             opcode_instruction, src_a, src_b, out_ready,
      input  in_ready, out_valid, result, zero, ALUcontrol, illegal
   );

   modport slave (
      input  flush, in_valid, ALUop, function_3bit, function_7bit,
             opcode_instruction, src_a, src_b, out_ready,
      output in_ready, out_valid, result, zero, ALUcontrol, illegal
   );
endinterface

// File: rtl/alu_exec_unit.sv
// RV32 EX-stage ALU. It combines the ALU-control decode, single-cycle execute, an optional iterative
// shift-add MUL, and a registered valid/ready result with a synchronous flush.
module alu_exec_unit #(
   parameter int XLEN   = 32,
   parameter bit MUL_EN = 1'b1
) (
   input  logic           clk,
   input  logic           rst,
   alu_exec_unit_if.slave bus
);
   localparam int SW = $clog2(XLEN);
   localparam logic [SW-1:0] CNT_LAST = SW'(XLEN - 1);

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_AND   = 4'd2,
      ALU_OR    = 4'd3,
      ALU_XOR   = 4'd4,
      ALU_SLL   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_SLT   = 4'd8,
      ALU_SLTU  = 4'd9,
      ALU_PASSB = 4'd10,
      ALU_MUL   = 4'd11
   } alu_ctrl_e;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_WAIT} state_e;

   state_e          state;
   logic [XLEN-1:0] mcand;
   logic [XLEN-1:0] mplier;
   logic [XLEN-1:0] acc;
   logic [SW-1:0]   cnt;

   logic            out_valid_q;
   logic [XLEN-1:0] result_q;
   logic            zero_q;
   alu_ctrl_e       ctrl_q;
   logic            illegal_q;

   alu_ctrl_e       dec_ctrl;
   logic            dec_illegal;
   logic [XLEN-1:0] alu_res;
   logic [SW-1:0]   shamt;
   logic            out_free;
   logic            accept;
   logic            unused_opcode;

   // Only opcode bit 5 (R-type vs I-type) affects the decode.
   assign unused_opcode = ^{bus.opcode_instruction[6], bus.opcode_instruction[4:0]};
   assign shamt         = bus.src_b[SW-1:0];

   // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
   always_comb begin
      dec_ctrl    = ALU_ADD;
      dec_illegal = 1'b0;
      case (bus.ALUop)
         2'b00: dec_ctrl = ALU_ADD;
         2'b01: dec_ctrl = ALU_SUB;
         2'b11: dec_ctrl = ALU_PASSB;
         default: begin
            if (bus.opcode_instruction[5] && bus.function_7bit == 7'b0000001) begin
               if (MUL_EN && bus.function_3bit == 3'b000) dec_ctrl = ALU_MUL;
               else                                       dec_illegal = 1'b1;
            end else begin
               case (bus.function_3bit)
                  3'b000:  dec_ctrl = (bus.opcode_instruction[5] && bus.function_7bit[5])
                                      ? ALU_SUB : ALU_ADD;
                  3'b001:  dec_ctrl = ALU_SLL;
                  3'b010:  dec_ctrl = ALU_SLT;
                  3'b011:  dec_ctrl = ALU_SLTU;
                  3'b100:  dec_ctrl = ALU_XOR;
                  3'b101:  dec_ctrl = bus.function_7bit[5] ? ALU_SRA : ALU_SRL;
                  3'b110:  dec_ctrl = ALU_OR;
                  default: dec_ctrl = ALU_AND;
               endcase
            end
         end
      endcase
   end

   always_comb begin
      alu_res = '0;
      case (dec_ctrl)
         ALU_ADD:   alu_res = bus.src_a + bus.src_b;
         ALU_SUB:   alu_res = bus.src_a - bus.src_b;
         ALU_AND:   alu_res = bus.src_a & bus.src_b;
         ALU_OR:    alu_res = bus.src_a | bus.src_b;
         ALU_XOR:   alu_res = bus.src_a ^ bus.src_b;
         ALU_SLL:   alu_res = bus.src_a << shamt;
         ALU_SRL:   alu_res = bus.src_a >> shamt;
         ALU_SRA:   alu_res = $signed(bus.src_a) >>> shamt;
         ALU_SLT:   alu_res = XLEN'($signed(bus.src_a) < $signed(bus.src_b));
         ALU_SLTU:  alu_res = XLEN'(bus.src_a < bus.src_b);
         ALU_PASSB: alu_res = bus.src_b;
         default:   alu_res = '0;
      endcase
      if (dec_illegal) alu_res = '0;
   end

   assign out_free     = !out_valid_q || bus.out_ready;
   assign bus.in_ready = (state == S_IDLE) && out_free && !bus.flush;
   assign accept       = bus.in_valid && bus.in_ready;

   // NOTE: sequential state uses non-blocking assignments only. A later load in this block
   // overrides the earlier out_valid clear on the same edge.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= S_IDLE;
         mcand       <= '0;
         mplier      <= '0;
         acc         <= '0;
         cnt         <= '0;
         out_valid_q <= 1'b0;
         result_q    <= '0;
         zero_q      <= 1'b0;
         ctrl_q      <= ALU_ADD;
         illegal_q   <= 1'b0;
      end else if (bus.flush) begin
         state       <= S_IDLE;
         out_valid_q <= 1'b0;
      end else begin
         if (bus.out_ready) out_valid_q <= 1'b0;
         case (state)
            S_IDLE: begin
               if (accept && dec_ctrl == ALU_MUL) begin
                  mcand  <= bus.src_a;
                  mplier <= bus.src_b;
                  acc    <= '0;
                  cnt    <= '0;
                  state  <= S_MUL;
               end else if (accept) begin
                  out_valid_q <= 1'b1;
                  result_q    <= alu_res;
                  zero_q      <= (alu_res == '0);
                  ctrl_q      <= dec_ctrl;
                  illegal_q   <= dec_illegal;
               end
            end
            S_MUL: begin
               if (mplier[0]) acc <= acc + mcand;
               mcand  <= mcand << 1;
               mplier <= mplier >> 1;
               cnt    <= cnt + SW'(1);
               if (cnt == CNT_LAST) state <= S_WAIT;
            end
            S_WAIT: begin
               // The product stays in acc until the output register is free.
               if (out_free) begin
                  out_valid_q <= 1'b1;
                  result_q    <= acc;
                  zero_q      <= (acc == '0);
                  ctrl_q      <= ALU_MUL;
                  illegal_q   <= 1'b0;
                  state       <= S_IDLE;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign bus.out_valid  = out_valid_q;
   assign bus.result     = result_q;
   assign bus.zero       = zero_q;
   assign bus.ALUcontrol = ctrl_q;
   assign bus.illegal    = illegal_q;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Testbench for alu_exec_unit. It applies directed cases and $urandom stimulus and checks the
// results against an arithmetic reference model of the ALU rules.
module tb_alu_exec_unit;
   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] F7_Z   = 7'b0000000;
   localparam logic [6:0] F7_ALT = 7'b0100000;
   localparam logic [6:0] F7_M   = 7'b0000001;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   alu_exec_unit_if #(.XLEN(32)) ifc ();
   alu_exec_unit_if #(.XLEN(32)) ifc0 ();

   alu_exec_unit #(.XLEN(32), .MUL_EN(1'b1)) u_dut (.clk(clk), .rst(rst), .bus(ifc));
   alu_exec_unit #(.XLEN(32), .MUL_EN(1'b0)) u_dut0 (.clk(clk), .rst(rst), .bus(ifc0));

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   // Reference: decoded class code, legality, and result computed with plain arithmetic.
   function automatic void model(input logic [1:0] aop, input logic [2:0] f3,
                                 input logic [6:0] f7, input logic [6:0] opc,
                                 input logic [31:0] a, input logic [31:0] b, input bit mul_en,
                                 output int code, output bit ill, output logic [31:0] res);
      int sh;
      sh   = int'(b % 32);
      ill  = 1'b0;
      code = 0;
      if (aop == 2'b00) code = 0;
      else if (aop == 2'b01) code = 1;
      else if (aop == 2'b11) code = 10;
      else if (opc[5] && f7 == F7_M) begin
         if (mul_en && f3 == 3'd0) code = 11;
         else ill = 1'b1;
      end else begin
         case (f3)
            3'd0: code = (opc[5] && f7[5]) ? 1 : 0;
            3'd1: code = 5;
            3'd2: code = 8;
            3'd3: code = 9;
            3'd4: code = 4;
            3'd5: code = f7[5] ? 7 : 6;
            3'd6: code = 3;
            default: code = 2;
         endcase
      end
      case (code)
         0:  res = a + b;
         1:  res = a - b;
         2:  res = a & b;
         3:  res = a | b;
         4:  res = a ^ b;
         5:  res = a << sh;
         6:  res = a >> sh;
         7:  res = (a[31] && sh != 0) ? ((a >> sh) | ~(32'hFFFF_FFFF >> sh)) : (a >> sh);
         8:  res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         9:  res = (a < b) ? 32'd1 : 32'd0;
         10: res = b;
         default: res = 32'(longint'(a) * longint'(b));
      endcase
      if (ill) res = 32'd0;
   endfunction

   task automatic drive(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b);
      ifc.ALUop              = aop;
      ifc.function_3bit      = f3;
      ifc.function_7bit      = f7;
      ifc.opcode_instruction = opc;
      ifc.src_a              = a;
      ifc.src_b              = b;
      ifc.in_valid           = 1'b1;
   endtask

   // Issue one op with out_ready=1 and check latency, busy in_ready and all registered outputs.
   task automatic run_op(input logic [1:0] aop, input logic [2:0] f3, input logic [6:0] f7,
                         input logic [6:0] opc, input logic [31:0] a, input logic [31:0] b,
                         input string tag);
      int          code;
      bit          ill;
      logic [31:0] exp;
      int          lat;
      bit          busy_ok;
      model(aop, f3, f7, opc, a, b, 1'b1, code, ill, exp);
      drive(aop, f3, f7, opc, a, b);
      ifc.out_ready = 1'b1;
      #1;
      check({tag, "/in_ready"}, ifc.in_ready, 1);
      @(posedge clk);
      #1;
      if (code == 11) ifc.in_valid = 1'b0;
      lat     = 0;
      busy_ok = 1'b1;
      while (!ifc.out_valid && lat < 100) begin
         if (ifc.in_ready) busy_ok = 1'b0;
         @(posedge clk);
         #1;
         lat++;
      end
      check({tag, "/latency"}, lat, (code == 11) ? 33 : 0);
      if (code == 11) check({tag, "/busy"}, busy_ok, 1);
      check({tag, "/result"}, ifc.result, exp);
      check({tag, "/zero"}, ifc.zero, (exp == 32'd0) ? 1 : 0);
      if (!ill) check({tag, "/ctrl"}, ifc.ALUcontrol, code);
      check({tag, "/illegal"}, ifc.illegal, ill);
   endtask

   initial begin
      int          code;
      bit          ill;
      logic [31:0] exp;
      logic [31:0] held;
      logic [6:0]  f7;
      logic [6:0]  opc;
      int          n;
      bit          stray;

      ifc.flush = 1'b0;  ifc.in_valid = 1'b0;  ifc.out_ready = 1'b1;
      ifc.ALUop = 2'b00; ifc.function_3bit = 3'd0; ifc.function_7bit = F7_Z;
      ifc.opcode_instruction = OP_R; ifc.src_a = '0; ifc.src_b = '0;
      ifc0.flush = 1'b0; ifc0.in_valid = 1'b0; ifc0.out_ready = 1'b1;
      ifc0.ALUop = 2'b00; ifc0.function_3bit = 3'd0; ifc0.function_7bit = F7_Z;
      ifc0.opcode_instruction = OP_R; ifc0.src_a = '0; ifc0.src_b = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst/out_valid", ifc.out_valid, 0);
      check("rst/result", ifc.result, 0);
      check("rst/zero", ifc.zero, 0);
      check("rst/ctrl", ifc.ALUcontrol, 0);
      check("rst/illegal", ifc.illegal, 0);
      check("rst/in_ready", ifc.in_ready, 1);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // R-type sweep, back to back: each run_op spends exactly one edge.
      run_op(2'b10, 3'b000, F7_Z,   OP_R, 32'hFFFF_FFF0, 32'h4, "add");
      check("add/const", ifc.result, 32'hFFFF_FFF4);
      run_op(2'b10, 3'b000, F7_ALT, OP_R, 32'hFFFF_FFF0, 32'h4, "sub");
      check("sub/const", ifc.result, 32'hFFFF_FFEC);
      run_op(2'b10, 3'b001, F7_Z,   OP_R, 32'hFFFF_FFF0, 32'h4, "sll");
      check("sll/const", ifc.result, 32'hFFFF_FF00);
      run_op(2'b10, 3'b101, F7_Z,   OP_R, 32'hFFFF_FFF0, 32'h4, "srl");
      check("srl/const", ifc.result, 32'h0FFF_FFFF);
      run_op(2'b10, 3'b101, F7_ALT, OP_R, 32'hFFFF_FFF0, 32'h4, "sra");
      check("sra/const", ifc.result, 32'hFFFF_FFFF);
      run_op(2'b10, 3'b010, F7_Z,   OP_R, 32'hFFFF_FFF0, 32'h4, "slt");
      check("slt/const", ifc.result, 32'd1);
      run_op(2'b10, 3'b011, F7_Z,   OP_R, 32'hFFFF_FFF0, 32'h4, "sltu");
      check("sltu/const", ifc.result, 32'd0);

      run_op(2'b01, 3'b000, F7_Z, OP_I, 32'd5, 32'd5, "beq");
      check("beq/zero", ifc.zero, 1);
      check("beq/ctrl", ifc.ALUcontrol, 1);
      ifc.in_valid = 1'b0;

      run_op(2'b10, 3'b000, F7_M, OP_R, 32'd7, 32'd6, "mul7x6");
      check("mul7x6/const", ifc.result, 32'd42);
      run_op(2'b10, 3'b000, F7_M, OP_R, 32'hFFFF_FFFF, 32'd2, "mulneg");
      check("mulneg/const", ifc.result, 32'hFFFF_FFFE);

      // Back-pressure across a completed MUL.
      ifc.in_valid = 1'b0;
      @(posedge clk);
      #1;
      ifc.out_ready = 1'b0;
      drive(2'b10, 3'b000, F7_M, OP_R, 32'h1234_5678, 32'd9);
      model(2'b10, 3'b000, F7_M, OP_R, 32'h1234_5678, 32'd9, 1'b1, code, ill, exp);
      #1;
      check("bp/in_ready", ifc.in_ready, 1);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      n = 0;
      while (!ifc.out_valid && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("bp/latency", n, 33);
      held = ifc.result;
      check("bp/result", held, exp);
      for (int i = 0; i < 4; i++) begin
         @(posedge clk);
         #1;
         check("bp/hold_valid", ifc.out_valid, 1);
         check("bp/hold_result", ifc.result, exp);
         check("bp/hold_in_ready", ifc.in_ready, 0);
      end
      ifc.out_ready = 1'b1;
      #1;
      check("bp/release_result", ifc.result, exp);
      @(posedge clk);
      #1;
      check("bp/consumed", ifc.out_valid, 0);

      // Flush mid-MUL: no output, in_ready back the next cycle.
      drive(2'b10, 3'b000, F7_M, OP_R, 32'd3, 32'd5);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      ifc.flush = 1'b1;
      @(posedge clk);
      #1;
      ifc.flush = 1'b0;
      #1;
      check("flush/in_ready", ifc.in_ready, 1);
      check("flush/out_valid", ifc.out_valid, 0);
      stray = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ifc.out_valid) stray = 1'b1;
      end
      check("flush/stray", stray, 0);
      run_op(2'b10, 3'b100, F7_Z, OP_I, 32'hA5A5_0F0F, 32'h0FF0_FF00, "postflush");

      // Reset asserted mid-MUL.
      drive(2'b10, 3'b000, F7_M, OP_R, 32'd11, 32'd13);
      @(posedge clk);
      #1;
      ifc.in_valid = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b0;
      #1;
      check("rstmul/out_valid", ifc.out_valid, 0);
      check("rstmul/result", ifc.result, 0);
      check("rstmul/zero", ifc.zero, 0);
      check("rstmul/ctrl", ifc.ALUcontrol, 0);
      check("rstmul/illegal", ifc.illegal, 0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      check("rstmul/in_ready", ifc.in_ready, 1);
      stray = 1'b0;
      repeat (40) begin
         @(posedge clk);
         #1;
         if (ifc.out_valid) stray = 1'b1;
      end
      check("rstmul/stray", stray, 0);

      // MUL_EN=0 instance: the MUL encoding becomes illegal and completes in one cycle.
      ifc0.ALUop = 2'b10; ifc0.function_3bit = 3'b000; ifc0.function_7bit = F7_M;
      ifc0.opcode_instruction = OP_R; ifc0.src_a = 32'd7; ifc0.src_b = 32'd6;
      ifc0.in_valid = 1'b1;
      #1;
      check("nomul/in_ready", ifc0.in_ready, 1);
      @(posedge clk);
      #1;
      check("nomul/out_valid", ifc0.out_valid, 1);
      check("nomul/illegal", ifc0.illegal, 1);
      check("nomul/result", ifc0.result, 0);
      check("nomul/zero", ifc0.zero, 1);
      ifc0.ALUop = 2'b00; ifc0.src_a = 32'd3; ifc0.src_b = 32'd4;
      @(posedge clk);
      #1;
      ifc0.in_valid = 1'b0;
      check("nomul_add/result", ifc0.result, 32'd7);
      check("nomul_add/illegal", ifc0.illegal, 0);

      // Randomized traffic, including an occasional MUL and undecodable op.
      for (int i = 0; i < 150; i++) begin
         case ($urandom_range(0, 3))
            0:       f7 = F7_Z;
            1:       f7 = F7_ALT;
            2:       f7 = F7_M;
            default: f7 = 7'($urandom);
         endcase
         opc = ($urandom_range(0, 1) != 0) ? OP_R : OP_I;
         run_op(2'($urandom), 3'($urandom), f7, opc, $urandom, $urandom, "rand");
      end
      for (int i = 0; i < 4; i++) begin
         run_op(2'b10, 3'b000, F7_M, OP_R, $urandom, $urandom, "rmul");
      end
      ifc.in_valid = 1'b0;
      @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not complete, %0d vectors applied", vectors);
      $fatal(1, "simulation time limit reached");
   end
endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

Parametrised ALU-control-plus-execute stage for the EX slot of the RV32 pipeline: decodes ALUop/funct3/funct7/opcode into a 4-bit ALU control code, computes the result, and registers it behind a valid/ready handshake. Single-cycle ops sustain one result per clock. Optional RV32M `MUL`, lower XLEN bits, runs as an iterative shift-add over XLEN cycles and back-pressures the front end while busy. A synchronous flush kills in-flight work on branch mispredict.

## Interface
Parameters:
- `XLEN`, default 32: operand/result width; must be a power of 2, ≥8.
- `MUL_EN`, default 1: 1 = `MUL` implemented; 0 = `funct7`=0000001 R-type is reported illegal.

Ports:
- `clk`, in, 1: single clock, rising edge.
- `rst`, in, 1: asynchronous, active-low reset.
- `flush`, in, 1: synchronous kill of the output register and any in-flight `MUL`.
- `in_valid`, in, 1: request valid.
- `in_ready`, out, 1: combinational; unit accepts this cycle.
- `ALUop`, in, 2: main-decoder ALU class.
- `function_3bit`, in, 3: `funct3`.
- `function_7bit`, in, 7: `funct7`.
- `opcode_instruction`, in, 7: opcode.
- `src_a`, in, XLEN: first operand.
- `src_b`, in, XLEN: second operand.
- `out_valid`, out, 1: result register holds a valid result.
- `out_ready`, in, 1: consumer takes the result.
- `result`, out, XLEN: registered result.
- `zero`, out, 1: registered; high when `result`==0.
- `ALUcontrol`, out, 4: registered control code of the result.
- `illegal`, out, 1: registered; high when the op was undecodable. `result` is 0 in that case.

## Operation
- Decode is combinational on the inputs and captured at accept.
- Control codes: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10, MUL=11.
- Decode by `ALUop`:
  - `ALUop`=00: ADD.
  - `ALUop`=01: SUB.
  - `ALUop`=11: PASSB (LUI).
  - `ALUop`=10, `opcode_instruction[5]`=1 and `function_7bit`=0000001: MUL if `MUL_EN` and `function_3bit`=000; otherwise illegal.
  - `ALUop`=10, all other cases, by `function_3bit`:
    - 000: SUB if `{opcode_instruction[5], function_7bit[5]}`=11, else ADD.
    - 001: SLL. 010: SLT. 011: SLTU. 100: XOR.
    - 101: SRA if `function_7bit[5]`, else SRL.
    - 110: OR. 111: AND.
- Arithmetic rules:
  - All arithmetic is modulo 2^XLEN.
  - Shift amount is `src_b[$clog2(XLEN)-1:0]`.
  - SLT is signed, SLTU is unsigned; both produce a 1-bit result, zero-extended.
- FSM states: IDLE, MUL, WAIT.
  - IDLE: on accept of a non-MUL op, load the output register. On accept of a MUL op, latch operands, clear the accumulator and counter, and go to MUL.
  - MUL: each cycle, if multiplier LSB is 1, add multiplicand to the accumulator; then shift multiplicand left and multiplier right, and increment the counter. After iteration XLEN, go to WAIT.
  - WAIT: when `!out_valid || out_ready`, load the accumulator into the output register with `out_valid`=1, then go to IDLE.
- `in_ready` = (state==IDLE) && (`!out_valid || out_ready`) && `!flush`.
- Accept happens when `in_valid && in_ready`.
- The output register drops `out_valid` when `out_ready` is high and no new load occurs in the same cycle.
- `flush`:
  - Next state is IDLE and `out_valid` is 0.
  - No accept occurs in that cycle.
  - Flush takes priority over every other event.
- Reset, including mid-MUL:
  - State IDLE, counter 0, accumulator 0.
  - All outputs 0 (`out_valid`, `result`, `zero`, `ALUcontrol`, `illegal`); `in_ready` reads 1.
  - An aborted MUL produces no output.

## Timing
- Single-cycle op accepted at edge N: `out_valid`/`result` visible after edge N. Latency is 1.
- Back-to-back single-cycle ops with `out_ready`=1 give throughput 1/clk.
- MUL accepted at edge N:
  - Iterations occur on edges N+1 through N+XLEN.
  - Output loads at edge N+XLEN+1 at the earliest; latency is XLEN+1.
  - `in_ready`=0 from after edge N until the FSM returns to IDLE.
- Stall: with `out_valid`=1 and `out_ready`=0, `result` and flags hold stable and `in_ready`=0.
- A WAIT with an unaccepted prior result holds the MUL result internally until the output frees.
- Simultaneous `out_ready` and accept in IDLE: the old result is consumed and the new one loaded on the same edge, with no bubble.

## Test plan
- Reset: assert `rst`=0 mid-MUL at XLEN=32. Required: all outputs 0, `in_ready`=1 after release, and no stray `out_valid`.
- R-type sweep, back to back with `out_ready`=1, `src_a`=0xFFFF_FFF0, `src_b`=0x0000_0004:
  - ADD→0xFFFF_FFF4, SUB→0xFFFF_FFEC, SLL→0xFFFF_FF00, SRL→0x0FFF_FFFF, SRA→0xFFFF_FFFF, SLT→1, SLTU→0.
  - One result per clock.
- Branch: `ALUop`=01 with `src_a`=`src_b`=5. Required: `result`=0, `zero`=1, `ALUcontrol`=1.
- MUL (`MUL_EN`=1, XLEN=32), 7×6. Required: `result`=42, `out_valid` exactly 33 edges after accept, `in_ready`=0 meanwhile. Also 0xFFFF_FFFF×2 → 0xFFFF_FFFE.
- Back-pressure: hold `out_ready`=0 across a completed MUL. Required: the result is held, `in_ready`=0, and the result is released unchanged one edge after `out_ready`=1.
- Flush mid-MUL and illegal ops:
  - Flush mid-MUL: no output, `in_ready`=1 next cycle.
  - `MUL_EN`=0 with `funct7`=0000001, `funct3`=000: `illegal`=1, `result`=0, latency 1.
